// File: rtl/step_loader_pkg.sv
// Shared decode constants for the step trace loader: frame layout, header tag and FSM states.
package step_loader_pkg;

  localparam logic [15:0] STEP_MAGIC = 16'h5354;
  localparam int          STEP_WORDS = 18;

  localparam int W_HDR     = 0;
  localparam int W_RAW_HI  = 1;
  localparam int W_RAW_MID = 2;
  localparam int W_RAW_LO  = 3;
  localparam int W_EAX     = 4;
  localparam int W_EBX     = 5;
  localparam int W_ECX     = 6;
  localparam int W_EDX     = 7;
  localparam int W_ESI     = 8;
  localparam int W_EDI     = 9;
  localparam int W_ESP     = 10;
  localparam int W_EBP     = 11;
  localparam int W_H1_CTRL = 12;
  localparam int W_H1_ADDR = 13;
  localparam int W_H1_DATA = 14;
  localparam int W_H2_CTRL = 15;
  localparam int W_H2_ADDR = 16;
  localparam int W_H2_DATA = 17;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } load_state_e;

  // Next expected step index, wrapping at the configured modulus.
  function automatic logic [15:0] nextIndex(input logic [15:0] idx, input int maxSteps);
    if (32'(idx) >= 32'(maxSteps - 1)) return 16'd0;
    return idx + 16'd1;
  endfunction

endpackage

// File: rtl/step_loader.sv
// Assembles 18-word step frames from the trace stream and presents them to decode
// through a single registered output slot, so one frame can load while another waits.
module step_loader #(
  parameter logic [15:0] STEP_MAGIC = 16'h5354,
  parameter int          MAX_STEPS  = 65536
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_word,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [95:0]   raw_instr,
  output logic [31:0]   eax,
  output logic [31:0]   ebx,
  output logic [31:0]   ecx,
  output logic [31:0]   edx,
  output logic [31:0]   esi,
  output logic [31:0]   edi,
  output logic [31:0]   esp,
  output logic [31:0]   ebp,
  output logic          hint1_is_write,
  output logic [31:0]   hint1_address,
  output logic [31:0]   hint1_data,
  output logic          hint2_is_write,
  output logic [31:0]   hint2_address,
  output logic [31:0]   hint2_data,
  output logic [15:0]   step_index,
  output logic          err_seq
);

  import step_loader_pkg::*;

  load_state_e r_state;
  load_state_e w_nextState;
  logic [4:0]  r_count;
  logic [4:0]  w_nextCount;
  logic [15:0] r_expIdx;
  logic [31:0] r_asm [STEP_WORDS];
  logic        r_inReady;
  logic        r_errSeq;
  logic        r_outValid;

  logic [95:0] r_rawInstr;
  logic [31:0] r_eax, r_ebx, r_ecx, r_edx, r_esi, r_edi, r_esp, r_ebp;
  logic        r_h1Write, r_h2Write;
  logic [31:0] r_h1Addr, r_h1Data, r_h2Addr, r_h2Data;
  logic [15:0] r_stepIdx;

  logic        w_accept;
  logic        w_slotFree;
  logic        w_hdrMagic;
  logic        w_hdrIdxOk;
  logic        w_transfer;
  logic        w_asmWe;
  logic        w_errSeq;
  logic        w_nextOutValid;
  logic [31:0] w_lastWord;

  assign w_accept   = in_valid && r_inReady;
  assign w_slotFree = !r_outValid || out_ready;
  assign w_hdrMagic = (in_word[31:16] == STEP_MAGIC);
  assign w_hdrIdxOk = (in_word[15:0] == r_expIdx);
  // The final word is still on the bus when a frame transfers straight out of LOAD.
  assign w_lastWord = (r_state == HOLD) ? r_asm[W_H2_DATA] : in_word;

  always_comb begin
    w_nextState    = r_state;
    w_nextCount    = r_count;
    w_transfer     = 1'b0;
    w_asmWe        = 1'b0;
    w_errSeq       = 1'b0;
    unique case (r_state)
      HUNT: begin
        if (w_accept && w_hdrMagic) begin
          if (w_hdrIdxOk) begin
            w_asmWe     = 1'b1;
            w_nextCount = 5'd1;
            w_nextState = LOAD;
          end else begin
            w_errSeq = 1'b1;
          end
        end
      end
      LOAD: begin
        if (w_accept) begin
          w_asmWe     = 1'b1;
          w_nextCount = r_count + 5'd1;
          if (r_count == 5'(W_H2_DATA)) begin
            if (w_slotFree) begin
              w_transfer  = 1'b1;
              w_nextCount = 5'd0;
              w_nextState = HUNT;
            end else begin
              w_nextState = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (w_slotFree) begin
          w_transfer  = 1'b1;
          w_nextCount = 5'd0;
          w_nextState = HUNT;
        end
      end
      default: w_nextState = HUNT;
    endcase
    w_nextOutValid = w_transfer || (r_outValid && !out_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= HUNT;
      r_count    <= 5'd0;
      r_expIdx   <= 16'd0;
      r_inReady  <= 1'b0;
      r_errSeq   <= 1'b0;
      r_outValid <= 1'b0;
      for (int i = 0; i < STEP_WORDS; i++) r_asm[i] <= 32'd0;
    end else begin
      r_state    <= w_nextState;
      r_count    <= w_nextCount;
      r_inReady  <= (w_nextState != HOLD);
      r_errSeq   <= w_errSeq;
      r_outValid <= w_nextOutValid;
      if (w_transfer) r_expIdx <= nextIndex(r_expIdx, MAX_STEPS);
      if (w_asmWe && (r_count < 5'(STEP_WORDS))) r_asm[r_count] <= in_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rawInstr <= 96'd0;
      r_eax      <= 32'd0;
      r_ebx      <= 32'd0;
      r_ecx      <= 32'd0;
      r_edx      <= 32'd0;
      r_esi      <= 32'd0;
      r_edi      <= 32'd0;
      r_esp      <= 32'd0;
      r_ebp      <= 32'd0;
      r_h1Write  <= 1'b0;
      r_h1Addr   <= 32'd0;
      r_h1Data   <= 32'd0;
      r_h2Write  <= 1'b0;
      r_h2Addr   <= 32'd0;
      r_h2Data   <= 32'd0;
      r_stepIdx  <= 16'd0;
    end else if (w_transfer) begin
      r_rawInstr <= {r_asm[W_RAW_HI], r_asm[W_RAW_MID], r_asm[W_RAW_LO]};
      r_eax      <= r_asm[W_EAX];
      r_ebx      <= r_asm[W_EBX];
      r_ecx      <= r_asm[W_ECX];
      r_edx      <= r_asm[W_EDX];
      r_esi      <= r_asm[W_ESI];
      r_edi      <= r_asm[W_EDI];
      r_esp      <= r_asm[W_ESP];
      r_ebp      <= r_asm[W_EBP];
      r_h1Write  <= r_asm[W_H1_CTRL][0];
      r_h1Addr   <= r_asm[W_H1_ADDR];
      r_h1Data   <= r_asm[W_H1_DATA];
      r_h2Write  <= r_asm[W_H2_CTRL][0];
      r_h2Addr   <= r_asm[W_H2_ADDR];
      r_h2Data   <= w_lastWord;
      r_stepIdx  <= r_asm[W_HDR][15:0];
    end
  end

  assign in_ready       = r_inReady;
  assign out_valid      = r_outValid;
  assign err_seq        = r_errSeq;
  assign raw_instr      = r_rawInstr;
  assign eax            = r_eax;
  assign ebx            = r_ebx;
  assign ecx            = r_ecx;
  assign edx            = r_edx;
  assign esi            = r_esi;
  assign edi            = r_edi;
  assign esp            = r_esp;
  assign ebp            = r_ebp;
  assign hint1_is_write = r_h1Write;
  assign hint1_address  = r_h1Addr;
  assign hint1_data     = r_h1Data;
  assign hint2_is_write = r_h2Write;
  assign hint2_address  = r_h2Addr;
  assign hint2_data     = r_h2Data;
  assign step_index     = r_stepIdx;

endmodule

// File: tb/tb_step_loader.sv
// Directed checks of step_loader: reset, framing, sequence errors, buffering, reset mid-frame, index wrap.
module tb_step_loader;

  // A small wrap modulus keeps the index-wrap scenario within a short run.
  localparam int TB_MAX_STEPS = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_word;
  logic          out_valid;
  logic          out_ready;
  logic [95:0]   raw_instr;
  logic [31:0]   eax, ebx, ecx, edx, esi, edi, esp, ebp;
  logic          hint1_is_write, hint2_is_write;
  logic [31:0]   hint1_address, hint1_data, hint2_address, hint2_data;
  logic [15:0]   step_index;
  logic          err_seq;

  int            nCompared = 0;
  int            nMismatched = 0;
  logic [31:0]   frame [18];
  logic [31:0]   savedEax;

  step_loader #(.STEP_MAGIC(16'h5354), .MAX_STEPS(TB_MAX_STEPS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .out_valid(out_valid), .out_ready(out_ready),
    .raw_instr(raw_instr),
    .eax(eax), .ebx(ebx), .ecx(ecx), .edx(edx),
    .esi(esi), .edi(edi), .esp(esp), .ebp(ebp),
    .hint1_is_write(hint1_is_write), .hint1_address(hint1_address), .hint1_data(hint1_data),
    .hint2_is_write(hint2_is_write), .hint2_address(hint2_address), .hint2_data(hint2_data),
    .step_index(step_index), .err_seq(err_seq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [95:0] observed, input logic [95:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Presents one word and waits (bounded) for it to be accepted.
  task automatic applyStimulus(input logic [31:0] w);
    int waited = 0;
    in_valid = 1'b1;
    in_word  = w;
    while (!in_ready && waited < 40) begin
      stepCycle();
      waited++;
    end
    checkOutput("in_ready_for_word", 96'(in_ready), 96'(1'b1));
    stepCycle();
    in_valid = 1'b0;
  endtask

  task automatic makeFrame(input logic [15:0] idx, input logic [31:0] base);
    frame[0] = {16'h5354, idx};
    for (int k = 1; k < 18; k++) frame[k] = base + 32'(k) * 32'h01010101;
  endtask

  task automatic sendWords(input int first, input int last);
    for (int k = first; k <= last; k++) applyStimulus(frame[k]);
  endtask

  task automatic checkFrame(input string tag);
    checkOutput({tag, "_raw"},   raw_instr, {frame[1], frame[2], frame[3]});
    checkOutput({tag, "_eax"},   96'(eax), 96'(frame[4]));
    checkOutput({tag, "_ecx"},   96'(ecx), 96'(frame[6]));
    checkOutput({tag, "_ebp"},   96'(ebp), 96'(frame[11]));
    checkOutput({tag, "_h1w"},   96'(hint1_is_write), 96'(frame[12][0]));
    checkOutput({tag, "_h1a"},   96'(hint1_address), 96'(frame[13]));
    checkOutput({tag, "_h2w"},   96'(hint2_is_write), 96'(frame[15][0]));
    checkOutput({tag, "_h2d"},   96'(hint2_data), 96'(frame[17]));
    checkOutput({tag, "_index"}, 96'(step_index), 96'(frame[0][15:0]));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_word = 32'd0; out_ready = 1'b0;
    repeat (3) stepCycle();
    checkOutput("rst_in_ready",  96'(in_ready), 96'(1'b0));
    checkOutput("rst_out_valid", 96'(out_valid), 96'(1'b0));
    checkOutput("rst_err_seq",   96'(err_seq), 96'(1'b0));
    checkOutput("rst_raw",       raw_instr, 96'd0);
    checkOutput("rst_index",     96'(step_index), 96'd0);
    rst = 1'b0;
    stepCycle();
    checkOutput("post_rst_in_ready", 96'(in_ready), 96'(1'b1));

    // Wrong index with correct magic.
    applyStimulus(32'h5354_0005);
    checkOutput("seq_err_pulse", 96'(err_seq), 96'(1'b1));
    stepCycle();
    checkOutput("seq_err_clear", 96'(err_seq), 96'(1'b0));
    checkOutput("seq_err_no_out", 96'(out_valid), 96'(1'b0));

    // Garbage is discarded silently.
    repeat (3) applyStimulus(32'hDEAD_BEEF);
    checkOutput("garbage_no_err", 96'(err_seq), 96'(1'b0));
    checkOutput("garbage_no_out", 96'(out_valid), 96'(1'b0));

    // First frame, consumer ready.
    out_ready = 1'b1;
    makeFrame(16'd0, 32'h1000_0000);
    frame[1] = 32'h0F1F_4400; frame[2] = 32'h9090_9090; frame[3] = 32'h9090_9090;
    frame[12] = 32'hFFFF_FFFE;
    sendWords(0, 16);
    checkOutput("a_not_yet_valid", 96'(out_valid), 96'(1'b0));
    sendWords(17, 17);
    checkOutput("a_valid", 96'(out_valid), 96'(1'b1));
    checkOutput("a_raw_literal", raw_instr, 96'h0F1F4400_90909090_90909090);
    checkFrame("a");
    stepCycle();
    checkOutput("a_consumed", 96'(out_valid), 96'(1'b0));

    // Two frames with the consumer stalled: second loads and then holds.
    out_ready = 1'b0;
    makeFrame(16'd1, 32'h2000_0001);
    savedEax = frame[4];
    sendWords(0, 17);
    checkOutput("b_valid", 96'(out_valid), 96'(1'b1));
    checkOutput("b_index", 96'(step_index), 96'd1);
    makeFrame(16'd2, 32'h3000_0003);
    frame[15] = 32'h0000_0001;
    sendWords(0, 17);
    checkOutput("c_hold_in_ready", 96'(in_ready), 96'(1'b0));
    repeat (2) stepCycle();
    checkOutput("b_stable_valid", 96'(out_valid), 96'(1'b1));
    checkOutput("b_stable_index", 96'(step_index), 96'd1);
    checkOutput("b_stable_eax",   96'(eax), 96'(savedEax));
    checkOutput("c_still_hold",   96'(in_ready), 96'(1'b0));
    out_ready = 1'b1;
    stepCycle();
    out_ready = 1'b0;
    checkOutput("c_no_gap_valid", 96'(out_valid), 96'(1'b1));
    checkFrame("c");
    checkOutput("c_ready_again", 96'(in_ready), 96'(1'b1));
    out_ready = 1'b1;
    stepCycle();
    checkOutput("c_consumed", 96'(out_valid), 96'(1'b0));

    // Reset part way through a frame.
    makeFrame(16'd3, 32'h4000_0000);
    sendWords(0, 9);
    rst = 1'b1;
    stepCycle();
    checkOutput("midrst_out_valid", 96'(out_valid), 96'(1'b0));
    checkOutput("midrst_in_ready",  96'(in_ready), 96'(1'b0));
    checkOutput("midrst_index",     96'(step_index), 96'd0);
    rst = 1'b0;
    stepCycle();
    checkOutput("midrst_resume", 96'(in_ready), 96'(1'b1));
    checkOutput("midrst_no_out", 96'(out_valid), 96'(1'b0));
    makeFrame(16'd0, 32'h5000_0005);
    sendWords(0, 17);
    checkOutput("d_valid", 96'(out_valid), 96'(1'b1));
    checkFrame("d");

    // Run the index up to the wrap point.
    for (int i = 1; i < TB_MAX_STEPS; i++) begin
      makeFrame(16'(i), 32'h6000_0000 + 32'(i));
      sendWords(0, 17);
      checkOutput("wrap_run_index", 96'(step_index), 96'(i));
    end
    applyStimulus({16'h5354, 16'(TB_MAX_STEPS)});
    checkOutput("wrap_past_modulus_err", 96'(err_seq), 96'(1'b1));
    makeFrame(16'd0, 32'h7000_0007);
    sendWords(0, 17);
    checkOutput("wrap_valid", 96'(out_valid), 96'(1'b1));
    checkFrame("wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
